wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone bus arbiter with ownership watchdog
module wb_rr_arbiter #(
    parameter int NUM_OF_MASTER   = 4,
    parameter int NUM_OF_SEL_BITS = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_OF_MASTER-1:0]   CYC_I,
    input  logic                       ACK_I,
    output logic [NUM_OF_SEL_BITS-1:0] GNT,
    output logic [NUM_OF_MASTER-1:0]   GNT_mux,
    output logic                       CYC,
    output logic                       busy,
    output logic                       timeout_err
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANTED    = 2'd1,
        BLOCKED    = 2'd2,
        TURNAROUND = 2'd3
    } state_t;

    localparam logic [NUM_OF_SEL_BITS-1:0] LAST_RST = NUM_OF_SEL_BITS'(NUM_OF_MASTER - 1);
    localparam logic [15:0]                WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [NUM_OF_SEL_BITS-1:0] gnt_q, gnt_d;
    logic [NUM_OF_SEL_BITS-1:0] last_q, last_d;
    logic [NUM_OF_MASTER-1:0]   mux_q, mux_d;
    logic [15:0]                wd_q, wd_d;
    logic                       armed_q;

    logic [NUM_OF_SEL_BITS-1:0] winner;
    logic [NUM_OF_SEL_BITS-1:0] idx;
    logic                       found;
    logic                       any_req;
    logic                       owner_cyc;
    logic                       wd_hit;

    assign any_req   = |CYC_I;
    assign owner_cyc = CYC_I[gnt_q];
    assign wd_hit    = (wd_q == WD_LIMIT) && !ACK_I;

    // Rotating search starting just past the previous owner, modulo the master count.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_OF_MASTER; i++) begin
            idx = NUM_OF_SEL_BITS'((int'(last_q) + i) % NUM_OF_MASTER);
            if (!found && CYC_I[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        mux_d       = mux_q;
        wd_d        = wd_q;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && any_req) begin
                    state_d        = GRANTED;
                    gnt_d          = winner;
                    mux_d          = '0;
                    mux_d[winner]  = 1'b1;
                    wd_d           = '0;
                end
            end
            GRANTED: begin
                // Release beats a coincident timeout; ACK beats the limit.
                if (!owner_cyc) begin
                    state_d = TURNAROUND;
                    last_d  = gnt_q;
                    mux_d   = '0;
                end else if (wd_hit) begin
                    state_d     = BLOCKED;
                    mux_d       = '0;
                    timeout_err = 1'b1;
                end else if (ACK_I) begin
                    wd_d = '0;
                end else if (wd_q != 16'hFFFF) begin
                    wd_d = wd_q + 16'd1;
                end
            end
            BLOCKED: begin
                if (!owner_cyc) begin
                    state_d = TURNAROUND;
                    last_d  = gnt_q;
                end
            end
            TURNAROUND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // armed_q holds off the first grant for one edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            mux_q   <= '0;
            wd_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            mux_q   <= mux_d;
            wd_q    <= wd_d;
            armed_q <= 1'b1;
        end
    end

    assign GNT     = gnt_q;
    assign GNT_mux = mux_q;
    assign CYC     = (state_q == GRANTED) && owner_cyc;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - self-checking bench for wb_rr_arbiter
module tb_wb_rr_arbiter;
    localparam int N = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cyc_i;
    logic       ack_i;
    logic [1:0] gnt;
    logic [3:0] gnt_mux;
    logic       cyc_o;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(
        .NUM_OF_MASTER  (N),
        .NUM_OF_SEL_BITS(2),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .CYC_I      (cyc_i),
        .ACK_I      (ack_i),
        .GNT        (gnt),
        .GNT_mux    (gnt_mux),
        .CYC        (cyc_o),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [3:0] cyc;
        logic       ack;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[16];

    // Reference model: who holds the bus, whether it was revoked, and a one-cycle cooldown.
    int m_holder, m_last, m_wd, m_gnt;
    bit m_revoked, m_cool, m_armed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] obs();
        return {gnt, gnt_mux, cyc_o, busy, timeout_err};
    endfunction

    task automatic model_init();
        m_holder = -1; m_last = N - 1; m_wd = 0; m_gnt = 0;
        m_revoked = 0; m_cool = 0; m_armed = 0;
    endtask

    function automatic logic [8:0] model_out(input logic [3:0] c, input logic a);
        logic [3:0] mx;
        logic       co, bz, to;
        mx = '0; co = 1'b0; to = 1'b0;
        if (m_holder >= 0 && !m_revoked) begin
            mx[m_holder] = 1'b1;
            co = c[m_holder];
            to = co && !a && (m_wd == T - 1);
        end
        bz = (m_holder >= 0) || m_cool;
        return {2'(m_gnt), mx, co, bz, to};
    endfunction

    task automatic model_step(input logic [3:0] c, input logic a);
        bit hit;
        if (m_cool) begin
            m_cool = 0;
        end else if (m_holder < 0) begin
            if (m_armed && c != 0) begin
                hit = 0;
                for (int i = 1; i <= N; i++) begin
                    if (!hit && c[(m_last + i) % N]) begin
                        hit = 1;
                        m_holder = (m_last + i) % N;
                    end
                end
                m_gnt = m_holder;
                m_wd = 0;
            end
        end else if (!c[m_holder]) begin
            m_last = m_holder; m_holder = -1; m_revoked = 0; m_cool = 1;
        end else if (!m_revoked) begin
            if (!a && m_wd == T - 1) m_revoked = 1;
            else if (a) m_wd = 0;
            else if (m_wd < 65535) m_wd++;
        end
        m_armed = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; cyc_i = '0; ack_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        model_init();
        m_armed = 1;
    endtask

    int         pulses, first, held, ng, rel;
    int         order[5];
    logic       stall;
    logic [8:0] expv;

    initial begin
        reset = 1'b0; cyc_i = '0; ack_i = 1'b0;
        #3;
        check("reset outputs", obs(), 9'd0);

        // Table-driven: basic grant, release, turnaround, wrap of the rotation.
        tbl[0]  = '{4'b0101, 1'b0, {2'd0, 4'b0000, 3'b000}};
        tbl[1]  = '{4'b0101, 1'b1, {2'd0, 4'b0001, 3'b110}};
        tbl[2]  = '{4'b0100, 1'b0, {2'd0, 4'b0001, 3'b010}};
        tbl[3]  = '{4'b0100, 1'b0, {2'd0, 4'b0000, 3'b010}};
        tbl[4]  = '{4'b0100, 1'b0, {2'd0, 4'b0000, 3'b000}};
        tbl[5]  = '{4'b0100, 1'b1, {2'd2, 4'b0100, 3'b110}};
        tbl[6]  = '{4'b0000, 1'b0, {2'd2, 4'b0100, 3'b010}};
        tbl[7]  = '{4'b0000, 1'b0, {2'd2, 4'b0000, 3'b010}};
        tbl[8]  = '{4'b1010, 1'b0, {2'd2, 4'b0000, 3'b000}};
        tbl[9]  = '{4'b1010, 1'b0, {2'd3, 4'b1000, 3'b110}};
        tbl[10] = '{4'b0010, 1'b0, {2'd3, 4'b1000, 3'b010}};
        tbl[11] = '{4'b0010, 1'b0, {2'd3, 4'b0000, 3'b010}};
        tbl[12] = '{4'b0010, 1'b0, {2'd3, 4'b0000, 3'b000}};
        tbl[13] = '{4'b0000, 1'b0, {2'd1, 4'b0010, 3'b010}};
        tbl[14] = '{4'b0000, 1'b0, {2'd1, 4'b0000, 3'b010}};
        tbl[15] = '{4'b0000, 1'b0, {2'd1, 4'b0000, 3'b000}};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc_i = tbl[i].cyc; ack_i = tbl[i].ack;
            #1;
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
            step();
        end

        // Continuous requests, each owner drops after two ACKs.
        do_reset();
        order = '{0, 1, 2, 3, 0};
        held = 0; ng = 0; rel = 0; ack_i = 1'b1;
        for (int cy = 0; cy < 60 && ng < 5; cy++) begin
            cyc_i = 4'b1111;
            if (gnt_mux != 0) begin
                if (held == 0) begin
                    check($sformatf("rr order%0d", ng), gnt, order[ng]);
                    if (ng > 0) check($sformatf("rr gap%0d", ng), cy - rel, 3);
                    ng++;
                end
                held++;
                if (held == 3) begin
                    cyc_i[gnt] = 1'b0;
                    rel = cy;
                end
            end else begin
                held = 0;
            end
            step();
        end
        check("rr grants", ng, 5);

        // Watchdog revocation of master 1, then release and hand-over.
        do_reset();
        cyc_i = 4'b0010; ack_i = 1'b0;
        step();
        pulses = 0; first = -1;
        for (int k = 0; k < 12; k++) begin
            if (k == 10) cyc_i = 4'b0011;
            #1;
            if (timeout_err) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == 9) begin
                check("blocked mux", gnt_mux, 0);
                check("blocked gnt", gnt, 1);
                check("blocked cyc", cyc_o, 0);
                check("blocked busy", busy, 1);
            end
            step();
        end
        check("to pulses", pulses, 1);
        check("to cycle", first, 7);
        cyc_i = 4'b0001;
        step();
        check("to turnaround", {busy, gnt_mux}, {1'b1, 4'b0000});
        step();
        check("to idle busy", busy, 0);
        step();
        check("to next grant", {gnt, gnt_mux}, {2'd0, 4'b0001});

        // ACK every 7 cycles keeps the owner alive.
        do_reset();
        cyc_i = 4'b0001;
        step();
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            ack_i = (k % 7 == 6);
            #1;
            if (timeout_err) pulses++;
            step();
        end
        check("ack7 no timeout", pulses, 0);

        // ACK exactly on the limit cycle clears the watchdog instead.
        do_reset();
        cyc_i = 4'b0001;
        step();
        pulses = 0; first = -1;
        for (int k = 0; k < 16; k++) begin
            ack_i = (k == 7);
            #1;
            if (timeout_err) begin
                pulses++;
                if (first < 0) first = k;
            end
            step();
        end
        check("ack limit pulses", pulses, 1);
        check("ack limit cycle", first, 15);

        // Release on the timeout cycle: straight to turnaround, no error.
        do_reset();
        cyc_i = 4'b0100; ack_i = 1'b0;
        step();
        for (int k = 0; k < 7; k++) step();
        cyc_i = 4'b0000;
        #1;
        check("rel@to err", timeout_err, 0);
        step();
        check("rel@to ta", {busy, gnt_mux}, {1'b1, 4'b0000});
        step();
        check("rel@to idle", busy, 0);

        // Reset mid-grant, then first grant to lowest index after release.
        do_reset();
        cyc_i = 4'b1000;
        step();
        check("pre-reset grant", {gnt, gnt_mux}, {2'd3, 4'b1000});
        #2 reset = 1'b0;
        #1;
        check("async reset outputs", obs(), 9'd0);
        cyc_i = 4'b1001;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        step();
        check("no grant 1st edge", {busy, gnt_mux}, 5'd0);
        step();
        check("grant after reset", {gnt, gnt_mux}, {2'd0, 4'b0001});

        // Randomized traffic against the reference model.
        do_reset();
        stall = 1'b0;
        for (int cy = 0; cy < 3000; cy++) begin
            if (cy % 64 == 0) stall = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < N; b++) begin
                if (cyc_i[b]) begin
                    if ($urandom_range(0, 5) == 0) cyc_i[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    cyc_i[b] = 1'b1;
                end
            end
            ack_i = stall ? 1'b0 : ($urandom_range(0, 2) == 0);
            #1;
            expv = model_out(cyc_i, ack_i);
            check($sformatf("rand@%0d", cy), obs(), expv);
            model_step(cyc_i, ack_i);
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
